// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 16-bit ALU and EX/MEM pipeline register.
// Optional iterative shift-add multiplier compiled in with EX_STAGE_MULT_EN.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] id_op1,
  input  logic [15:0] id_op2,
  input  logic [15:0] id_imm,
  input  logic        id_use_imm,
  input  logic [2:0]  id_alu_op,
  input  logic [3:0]  id_rd,
  input  logic        id_regwrite,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [15:0] em_result,
  input  logic [15:0] mwb_result,
  input  logic        flush,
  output logic        busy,
  output logic        em_valid,
  output logic [15:0] em_alu_result,
  output logic [3:0]  em_rd,
  output logic        em_regwrite,
  output logic        em_zero
);

  logic [15:0] op_a;
  logic [15:0] op_b_fwd;
  logic [15:0] op_b;
  logic [15:0] alu_out;
  logic        accept;
  logic        done;
  logic [15:0] done_result;
  logic [3:0]  done_rd;
  logic        done_regwrite;

  // Select 11 deliberately falls back to the register-file value.
  always_comb begin
    op_a     = id_op1;
    op_b_fwd = id_op2;
    case (fwd_a)
      2'b10:   op_a = em_result;
      2'b01:   op_a = mwb_result;
      default: op_a = id_op1;
    endcase
    case (fwd_b)
      2'b10:   op_b_fwd = em_result;
      2'b01:   op_b_fwd = mwb_result;
      default: op_b_fwd = id_op2;
    endcase
    op_b = id_use_imm ? id_imm : op_b_fwd;
  end

  always_comb begin
    alu_out = 16'h0000;
    case (id_alu_op)
      3'b000:  alu_out = op_a + op_b;
      3'b001:  alu_out = op_a - op_b;
      3'b010:  alu_out = op_a & op_b;
      3'b011:  alu_out = op_a | op_b;
      3'b100:  alu_out = op_a ^ op_b;
      3'b101:  alu_out = op_a << op_b[3:0];
      3'b110:  alu_out = op_a >> op_b[3:0];
      default: alu_out = 16'h0000;
    endcase
  end

  assign accept = id_valid & ~busy & ~flush;

`ifdef EX_STAGE_MULT_EN
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic        is_mul;
  logic        mul_done;
  logic [3:0]  count;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [15:0] acc_step;
  logic [3:0]  mul_rd;
  logic        mul_regwrite;

  assign is_mul   = (id_alu_op == 3'b111);
  assign busy     = (state == BUSY);
  assign acc_step = acc + (mplier[0] ? mcand : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_done   = 1'b0;
    case (state)
      IDLE: if (accept && is_mul) state_next = BUSY;
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count == 4'd15) begin
          state_next = IDLE;
          mul_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sixteen shift-add steps; the final step's sum goes straight to EX/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 4'd0;
      mcand        <= 16'h0000;
      mplier       <= 16'h0000;
      acc          <= 16'h0000;
      mul_rd       <= 4'd0;
      mul_regwrite <= 1'b0;
    end else if (state == IDLE) begin
      count <= 4'd0;
      if (accept && is_mul) begin
        mcand        <= op_a;
        mplier       <= op_b;
        acc          <= 16'h0000;
        mul_rd       <= id_rd;
        mul_regwrite <= id_regwrite;
      end
    end else if (flush) begin
      count <= 4'd0;
    end else begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 4'd1;
    end
  end

  assign done          = (accept & ~is_mul) | mul_done;
  assign done_result   = mul_done ? acc_step : alu_out;
  assign done_rd       = mul_done ? mul_rd : id_rd;
  assign done_regwrite = mul_done ? mul_regwrite : id_regwrite;
`else
  assign busy          = 1'b0;
  assign done          = accept;
  assign done_result   = alu_out;
  assign done_rd       = id_rd;
  assign done_regwrite = id_regwrite;
`endif

  // Anything other than a completion loads a bubble so nothing stale is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid      <= 1'b0;
      em_alu_result <= 16'h0000;
      em_rd         <= 4'd0;
      em_regwrite   <= 1'b0;
    end else if (done) begin
      em_valid      <= 1'b1;
      em_alu_result <= done_result;
      em_rd         <= done_rd;
      em_regwrite   <= done_regwrite;
    end else begin
      em_valid      <= 1'b0;
      em_alu_result <= 16'h0000;
      em_rd         <= 4'd0;
      em_regwrite   <= 1'b0;
    end
  end

  assign em_zero = (em_alu_result == 16'h0000);

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; MUL scenarios follow EX_STAGE_MULT_EN.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_op1;
  logic [15:0] id_op2;
  logic [15:0] id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_op;
  logic [3:0]  id_rd;
  logic        id_regwrite;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] em_result;
  logic [15:0] mwb_result;
  logic        flush;
  logic        busy;
  logic        em_valid;
  logic [15:0] em_alu_result;
  logic [3:0]  em_rd;
  logic        em_regwrite;
  logic        em_zero;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .fwd_a(fwd_a), .fwd_b(fwd_b), .em_result(em_result),
    .mwb_result(mwb_result), .flush(flush), .busy(busy), .em_valid(em_valid),
    .em_alu_result(em_alu_result), .em_rd(em_rd), .em_regwrite(em_regwrite), .em_zero(em_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] rd, input logic rw);
    id_valid    = v;
    id_alu_op   = op;
    id_op1      = a;
    id_op2      = b;
    id_rd       = rd;
    id_regwrite = rw;
    id_use_imm  = 1'b0;
    id_imm      = 16'h0000;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
    em_result  = 16'h0;
    mwb_result = 16'h0;
    #23;
    n_checks++;
    if ({busy, em_valid, em_alu_result, em_rd, em_regwrite, em_zero} !== {1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got busy=%b v=%b res=%h rd=%h rw=%b z=%b, want 0 0 0000 0 0 1",
               busy, em_valid, em_alu_result, em_rd, em_regwrite, em_zero);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // First edge after reset release must already accept.
  task automatic test_add();
    drive(1'b1, 3'b000, 16'h0005, 16'h0003, 4'd7, 1'b1);
    tick();
    n_checks++;
    if ({em_valid, em_alu_result, em_zero, em_rd, em_regwrite} !== {1'b1, 16'h0008, 1'b0, 4'd7, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL add_first: got v=%b res=%h z=%b rd=%h rw=%b, want 1 0008 0 7 1",
               em_valid, em_alu_result, em_zero, em_rd, em_regwrite);
    end
    drive(1'b0, 3'b000, 16'h1234, 16'h1111, 4'd3, 1'b1);
    tick();
    n_checks++;
    if ({em_valid, em_alu_result, em_zero, em_rd, em_regwrite} !== {1'b0, 16'h0, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL bubble: got v=%b res=%h z=%b rd=%h rw=%b, want 0 0000 1 0 0",
               em_valid, em_alu_result, em_zero, em_rd, em_regwrite);
    end
  endtask

  task automatic test_forwarding();
    logic [15:0] exp_res [4] = '{16'h0000, 16'h00D0, 16'h1111, 16'h0035};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b001, 16'h3333, 16'h2222, 4'd2, 1'b1);
      case (i)
        0: begin fwd_a = 2'b10; fwd_b = 2'b01; em_result = 16'h0010; mwb_result = 16'h0010; end
        1: begin fwd_a = 2'b01; fwd_b = 2'b10; em_result = 16'h0030; mwb_result = 16'h0100; end
        2: begin fwd_a = 2'b11; fwd_b = 2'b11; em_result = 16'hAAAA; mwb_result = 16'hBBBB; end
        default: begin
          id_alu_op = 3'b000; fwd_a = 2'b10; fwd_b = 2'b10; id_use_imm = 1'b1;
          id_imm = 16'h0005; em_result = 16'h0030; mwb_result = 16'h0000;
        end
      endcase
      tick();
      n_checks++;
      if ({em_valid, em_alu_result, em_zero} !== {1'b1, exp_res[i], exp_res[i] == 16'h0}) begin
        n_fail++;
        $display("[TB] FAIL forward_%0d: got v=%b res=%h z=%b, want 1 %h %b",
                 i, em_valid, em_alu_result, em_zero, exp_res[i], exp_res[i] == 16'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [8] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b001, 3'b000};
    logic [15:0] as  [8] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h1234};
    logic [15:0] bs  [8] = '{16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0013, 16'h000F, 16'h0001, 16'h0001, 16'h0000};
    logic [15:0] exp [8] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0008, 16'h0001, 16'h0000, 16'hFFFF, 16'h1234};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 4'(i), i[0]);
      tick();
      n_checks++;
      if ({em_valid, em_alu_result, em_zero, em_rd, em_regwrite} !==
          {1'b1, exp[i], exp[i] == 16'h0, 4'(i), i[0]}) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d: got v=%b res=%h z=%b rd=%h rw=%b, want 1 %h %b %h %b",
                 i, em_valid, em_alu_result, em_zero, em_rd, em_regwrite,
                 exp[i], exp[i] == 16'h0, 4'(i), i[0]);
      end
    end
  endtask

  task automatic test_rd_zero_and_flush();
    drive(1'b1, 3'b011, 16'h0A00, 16'h000B, 4'd0, 1'b1);
    tick();
    n_checks++;
    if ({em_valid, em_alu_result, em_rd, em_regwrite} !== {1'b1, 16'h0A0B, 4'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL rd_zero: got v=%b res=%h rd=%h rw=%b, want 1 0a0b 0 1",
               em_valid, em_alu_result, em_rd, em_regwrite);
    end
    drive(1'b1, 3'b000, 16'h0101, 16'h0202, 4'd9, 1'b1);
    flush = 1'b1;
    tick();
    n_checks++;
    if ({em_valid, em_alu_result, em_rd, em_regwrite, em_zero} !== {1'b0, 16'h0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL flush_idle: got v=%b res=%h rd=%h rw=%b z=%b, want 0 0000 0 0 1",
               em_valid, em_alu_result, em_rd, em_regwrite, em_zero);
    end
  endtask

  task automatic test_mul();
`ifdef EX_STAGE_MULT_EN
    int busy_cycles;
    bit dropped;
    drive(1'b1, 3'b111, 16'h0123, 16'h0010, 4'd5, 1'b1);
    tick();
    drive(1'b1, 3'b000, 16'h0002, 16'h0003, 4'd6, 1'b1);
    busy_cycles = 0;
    dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      if (busy) begin
        busy_cycles++;
        if (em_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL mul_early_valid: got em_valid=%b during busy, want 0", em_valid);
        end
        tick();
      end else begin
        dropped = 1'b1;
      end
    end
    n_checks++;
    if (!dropped || busy_cycles != 16) begin
      n_fail++;
      $display("[TB] FAIL mul_busy_len: got %0d busy cycles (dropped=%b), want 16", busy_cycles, dropped);
    end
    n_checks++;
    if ({em_valid, em_alu_result, em_rd, em_regwrite} !== {1'b1, 16'h1230, 4'd5, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL mul_result: got v=%b res=%h rd=%h rw=%b, want 1 1230 5 1",
               em_valid, em_alu_result, em_rd, em_regwrite);
    end
    tick();
    n_checks++;
    if ({busy, em_valid, em_alu_result, em_rd} !== {1'b0, 1'b1, 16'h0005, 4'd6}) begin
      n_fail++;
      $display("[TB] FAIL mul_then_add: got busy=%b v=%b res=%h rd=%h, want 0 1 0005 6",
               busy, em_valid, em_alu_result, em_rd);
    end
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
    tick();
`else
    drive(1'b1, 3'b111, 16'h0123, 16'h0010, 4'd5, 1'b1);
    tick();
    n_checks++;
    if ({busy, em_valid, em_alu_result, em_zero, em_rd} !== {1'b0, 1'b1, 16'h0, 1'b1, 4'd5}) begin
      n_fail++;
      $display("[TB] FAIL mul_disabled: got busy=%b v=%b res=%h z=%b rd=%h, want 0 1 0000 1 5",
               busy, em_valid, em_alu_result, em_zero, em_rd);
    end
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
    tick();
`endif
  endtask

  task automatic test_mul_flush();
`ifdef EX_STAGE_MULT_EN
    int stray;
    drive(1'b1, 3'b111, 16'h0003, 16'h0005, 4'd4, 1'b1);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mul_flush_pre: got busy=%b at iteration 7, want 1", busy);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({busy, em_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mul_flush_abort: got busy=%b v=%b, want 0 0", busy, em_valid);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (em_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("[TB] FAIL mul_flush_stray: got %0d cycles with valid/busy after flush, want 0", stray);
    end
`endif
  endtask

  task automatic test_async_reset();
    int stray;
    drive(1'b1, 3'b100, 16'h00FF, 16'h0F0F, 4'd8, 1'b1);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
`ifdef EX_STAGE_MULT_EN
    drive(1'b1, 3'b111, 16'h0007, 16'h0009, 4'd3, 1'b1);
    tick();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 1'b0);
    tick();
    tick();
`endif
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, em_valid, em_alu_result, em_rd, em_regwrite, em_zero} !== {1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got busy=%b v=%b res=%h rd=%h rw=%b z=%b, want 0 0 0000 0 0 1",
               busy, em_valid, em_alu_result, em_rd, em_regwrite, em_zero);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (em_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_stale: got %0d cycles with valid/busy after release, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_back_to_back();
    test_rd_zero_and_flush();
    test_mul();
    test_mul_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port id_valid, input, 1 bit: ID/EX holds a valid instruction.
REQ-004 SHALL have ports id_op1 and id_op2, input, 16 bits each: register-file operand values A and B.
REQ-005 SHALL have port id_imm, input, 16 bits: immediate value.
REQ-006 SHALL have port id_use_imm, input, 1 bit: immediate replaces operand B.
REQ-007 SHALL have port id_alu_op, input, 3 bits: operation code.
REQ-008 SHALL have port id_rd, input, 4 bits: destination register ID.
REQ-009 SHALL have port id_regwrite, input, 1 bit: instruction writes id_rd.
REQ-010 SHALL have ports fwd_a and fwd_b, input, 2 bits each: forwarding selects for operands A and B.
REQ-011 SHALL have port em_result, input, 16 bits: EX/MEM ALU result, forwarded.
REQ-012 SHALL have port mwb_result, input, 16 bits: MEM/WB write-back value, forwarded.
REQ-013 SHALL have port flush, input, 1 bit: kill the in-flight or incoming instruction.
REQ-014 SHALL have port busy, output, 1 bit: upstream holds ID/EX contents while high.
REQ-015 SHALL have port em_valid, output, 1 bit: EX/MEM register holds a valid result.
REQ-016 SHALL have port em_alu_result, output, 16 bits: registered result.
REQ-017 SHALL have port em_rd, output, 4 bits: registered destination register ID.
REQ-018 SHALL have port em_regwrite, output, 1 bit: registered write enable.
REQ-019 SHALL have port em_zero, output, 1 bit: high when em_alu_result == 0.

Function
REQ-020 Operand select SHALL be: 00 = id_opN, 10 = em_result, 01 = mwb_result, 11 = id_opN; operand B is then replaced by id_imm when id_use_imm=1.
REQ-021 Accept SHALL occur when id_valid=1, busy=0 and flush=0; operands are captured at accept.
REQ-022 ALU ops SHALL be 16-bit modulo: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by B[3:0], 110 SHR logical by B[3:0], 111 MUL (low 16 bits of product).
REQ-023 Ops 000-110 SHALL load EX/MEM on the edge that accepts them, with em_valid=1 next cycle (1-cycle latency).
REQ-024 MUL SHALL use FSM IDLE->BUSY: accept moves IDLE->BUSY; BUSY runs exactly 16 shift-add iterations (counter 0..15); on the 16th BUSY edge it loads EX/MEM, sets em_valid=1 and returns to IDLE.
REQ-025 busy SHALL equal (state==BUSY), registered, and SHALL never depend combinationally on inputs.
REQ-026 On any cycle with no completion, the EX/MEM register SHALL be loaded with a bubble: em_valid=0, em_regwrite=0, em_rd=0, em_alu_result=0.
REQ-027 em_regwrite SHALL equal id_regwrite AND valid completion, so bubbles are never forwarded.
REQ-028 flush SHALL have priority over id_valid: no accept, abort BUSY to IDLE with the counter cleared, and load a bubble on that edge.
REQ-029 A new instruction SHALL be accepted on the cycle immediately after MUL completion (busy low).
REQ-030 id_rd=0 SHALL be passed through unchanged; suppression of writes to register 0 is downstream's responsibility.

Reset
REQ-031 rst_n low SHALL asynchronously force: state=IDLE, counter=0, busy=0, em_valid=0, em_alu_result=0, em_rd=0, em_regwrite=0, em_zero=1.
REQ-032 Reset asserted mid-MUL SHALL discard the operation with no result emitted after release.
REQ-033 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro EX_STAGE_MULT_EN: when defined, MUL and the IDLE/BUSY FSM SHALL be compiled in per REQ-024.
REQ-035 Without EX_STAGE_MULT_EN, op 111 SHALL complete in 1 cycle with result 0x0000, busy SHALL be tied to 0, and no FSM or counter logic SHALL exist.

Verification
REQ-036 ADD op1=0x0005, op2=0x0003, fwd=00 -> next cycle em_valid=1, em_alu_result=0x0008, em_zero=0.
REQ-037 SUB with fwd_a=10, em_result=0x0010, fwd_b=01, mwb_result=0x0010 -> em_alu_result=0x0000, em_zero=1.
REQ-038 MUL 0x0123 x 0x0010 (MULT_EN defined) -> busy high exactly 16 cycles, then em_alu_result=0x1230 and em_valid=1 for 1 cycle; a queued ADD is accepted the cycle after.
REQ-039 flush asserted at MUL iteration 7 -> busy falls next cycle, em_valid stays 0, no result emitted.
REQ-040 rst_n pulsed low mid-MUL -> all outputs at reset values immediately, without a clock edge; no stale result after release.
